bus_select_encoder: RTL and testbench

//  Control-side encoder for the 24-source datapath bus. Converts one-hot source-drive requests (R0out..R15out,

---
 rtl/bus_select_encoder.sv | 135 +++++++++++++
 tb/tb_bus_select_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_select_encoder.sv
// Registered one-hot to 5-bit bus select encoder with conflict tracking and lock/hold handshake.
// Optional build macro BUS_ENC_STRICT_EN: conflicting requests grant nothing instead of the priority winner.
module bus_select_encoder #(
    parameter logic [4:0] IDLE_CODE = 5'd31,
    parameter int         CNT_W     = 8,
    parameter int         LOCK_MAX  = 15
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [23:0]      out_req,
    input  logic             bus_lock,
    output logic [4:0]       BusMuxControl,
    output logic             bus_valid,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_count,
    output logic             lock_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LOCKED} state_t;

    localparam logic [7:0]       LOCK_MAX_C = 8'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_code, w_code_nxt;
    logic [7:0]       r_lock_cnt, w_lock_cnt_nxt;
    logic             r_lock_blk, w_lock_blk_nxt;
    logic             r_conflict, r_sticky, r_timeout;
    logic [CNT_W-1:0] r_conf_cnt;
    logic [4:0]       w_winner;
    logic             w_any, w_multi, w_grant_ok, w_timeout;

    // Ascending scan: the last set bit seen is the highest index, i.e. highest priority.
    always_comb begin
        w_winner = 5'd0;
        for (int i = 0; i < 24; i++)
            if (out_req[i]) w_winner = 5'(i);
    end

    assign w_any   = |out_req;
    assign w_multi = (out_req & (out_req - 24'd1)) != 24'd0;

`ifdef BUS_ENC_STRICT_EN
    assign w_grant_ok = w_any & ~w_multi;
`else
    assign w_grant_ok = w_any;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_lock_cnt_nxt = r_lock_cnt;
        // A timeout blocks re-locking until bus_lock has been seen low.
        w_lock_blk_nxt = r_lock_blk & bus_lock;
        w_timeout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = S_DRIVE;
                    w_code_nxt  = w_winner;
                end else begin
                    w_code_nxt  = IDLE_CODE;
                end
            end
            S_DRIVE: begin
                if (bus_lock && !r_lock_blk) begin
                    w_state_nxt    = S_LOCKED;
                    w_lock_cnt_nxt = 8'd1;
                end else if (w_grant_ok) begin
                    w_code_nxt  = w_winner;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = IDLE_CODE;
                end
            end
            S_LOCKED: begin
                if (!bus_lock) begin
                    w_lock_cnt_nxt = 8'd0;
                    if (w_grant_ok) begin
                        w_state_nxt = S_DRIVE;
                        w_code_nxt  = w_winner;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_code_nxt  = IDLE_CODE;
                    end
                end else if (r_lock_cnt >= LOCK_MAX_C) begin
                    w_state_nxt    = S_IDLE;
                    w_code_nxt     = IDLE_CODE;
                    w_lock_cnt_nxt = 8'd0;
                    w_lock_blk_nxt = 1'b1;
                    w_timeout      = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_code_nxt     = IDLE_CODE;
                w_lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_code     <= IDLE_CODE;
            r_lock_cnt <= 8'd0;
            r_lock_blk <= 1'b0;
            r_conflict <= 1'b0;
            r_sticky   <= 1'b0;
            r_conf_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock_blk <= w_lock_blk_nxt;
            r_conflict <= w_multi;
            r_sticky   <= r_sticky | w_multi;
            r_timeout  <= w_timeout;
            if (w_multi && (r_conf_cnt != '1))
                r_conf_cnt <= r_conf_cnt + CNT_ONE;
        end
    end

    assign BusMuxControl   = r_code;
    assign bus_valid       = (r_code != IDLE_CODE);
    assign conflict        = r_conflict;
    assign conflict_sticky = r_sticky;
    assign conflict_count  = r_conf_cnt;
    assign lock_timeout    = r_timeout;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Scoreboard bench for bus_select_encoder: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_bus_select_encoder;

    logic        clock = 1'b0;
    logic        clear;
    logic [23:0] out_req;
    logic        bus_lock;
    logic [4:0]  BusMuxControl;
    logic        bus_valid, conflict, conflict_sticky, lock_timeout;
    logic [7:0]  conflict_count;

    typedef struct packed {
        logic [15:0] id;
        logic [4:0]  code;
        logic        conf;
        logic        sticky;
        logic [7:0]  cnt;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   step_id = 0;

`ifdef BUS_ENC_STRICT_EN
    localparam logic [4:0] CONF_CODE = 5'd31;
`else
    localparam logic [4:0] CONF_CODE = 5'd20;
`endif
    localparam logic [23:0] CONF_REQ = (24'd1 << 20) | (24'd1 << 2);

    bus_select_encoder #(.IDLE_CODE(5'd31), .CNT_W(8), .LOCK_MAX(15)) dut (
        .clock(clock), .clear(clear), .out_req(out_req), .bus_lock(bus_lock),
        .BusMuxControl(BusMuxControl), .bus_valid(bus_valid), .conflict(conflict),
        .conflict_sticky(conflict_sticky), .conflict_count(conflict_count),
        .lock_timeout(lock_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s step=%0d act=%0d exp=%0d", nm, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after the next edge.
    task automatic step(input logic [23:0] req, input logic lk, input int code,
                        input logic cf, input logic st, input int cnt, input logic to);
        exp_t e;
        @(negedge clock);
        out_req  = req;
        bus_lock = lk;
        step_id++;
        e.id = 16'(step_id); e.code = 5'(code); e.conf = cf; e.sticky = st;
        e.cnt = 8'(cnt); e.to = to;
        q.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clock);
            #2;
            guard++;
        end
        if (q.size() != 0) chk("drain", 0, q.size(), 0);
    endtask

    task automatic chk_reset(input int id);
        chk("rst_code",   id, BusMuxControl,   31);
        chk("rst_valid",  id, bus_valid,       0);
        chk("rst_conf",   id, conflict,        0);
        chk("rst_sticky", id, conflict_sticky, 0);
        chk("rst_cnt",    id, conflict_count,  0);
        chk("rst_to",     id, lock_timeout,    0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("code",   e.id, BusMuxControl,   e.code);
                chk("valid",  e.id, bus_valid,       (e.code != 5'd31));
                chk("conf",   e.id, conflict,        e.conf);
                chk("sticky", e.id, conflict_sticky, e.sticky);
                chk("count",  e.id, conflict_count,  e.cnt);
                chk("timeout",e.id, lock_timeout,    e.to);
            end
        end
    end

    initial begin : stim
        clear = 1'b0; out_req = '0; bus_lock = 1'b0;
        #12;
        chk_reset(0);
        @(negedge clock);
        clear = 1'b1;

        // single sources and return to idle
        step(24'd0,        0, 31, 0, 0, 0, 0);
        step(24'd1 << 23,  0, 23, 0, 0, 0, 0);
        step(24'd1 << 3,   0, 3,  0, 0, 0, 0);
        step(24'd0,        0, 31, 0, 0, 0, 0);

        // sweep every source
        for (int i = 0; i < 24; i++) step(24'd1 << i, 0, i, 0, 0, 0, 0);
        step(24'd0, 0, 31, 0, 0, 0, 0);

        // lock holds code 6 while request moves to 9
        step(24'd1 << 6, 0, 6,  0, 0, 0, 0);
        step(24'd1 << 6, 1, 6,  0, 0, 0, 0);
        step(24'd1 << 9, 1, 6,  0, 0, 0, 0);
        step(24'd1 << 9, 0, 9,  0, 0, 0, 0);
        step(24'd0,      0, 31, 0, 0, 0, 0);

        // lock timeout after 15 locked cycles, then no re-lock until bus_lock toggles
        step(24'd1 << 4, 0, 4, 0, 0, 0, 0);
        step(24'd1 << 4, 1, 4, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) step(24'd1 << 4, 1, 4, 0, 0, 0, 0);
        step(24'd1 << 4, 1, 31, 0, 0, 0, 1);
        step(24'd1 << 4, 1, 4,  0, 0, 0, 0);
        step(24'd1 << 4, 1, 4,  0, 0, 0, 0);
        step(24'd1 << 5, 1, 5,  0, 0, 0, 0);
        step(24'd1 << 5, 0, 5,  0, 0, 0, 0);
        step(24'd1 << 7, 1, 5,  0, 0, 0, 0);
        step(24'd1 << 7, 0, 7,  0, 0, 0, 0);
        step(24'd0,      0, 31, 0, 0, 0, 0);

        // conflict pulse, sticky, saturating count
        step(CONF_REQ, 0, CONF_CODE, 1, 1, 1, 0);
        step(24'd0,    0, 31,        0, 1, 1, 0);
        for (int k = 1; k <= 300; k++)
            step(CONF_REQ, 0, CONF_CODE, 1, 1, (1 + k > 255) ? 255 : 1 + k, 0);
        step(24'd0, 0, 31, 0, 1, 255, 0);

        // reset asserted while locked
        step(24'd1 << 1, 0, 1, 0, 1, 255, 0);
        step(24'd1 << 1, 1, 1, 0, 1, 255, 0);
        drain();
        @(negedge clock);
        clear = 1'b0;
        #1;
        chk_reset(1000);
        @(negedge clock);
        clear = 1'b1;
        step(24'd1 << 1, 1, 1,  0, 0, 0, 0);
        step(24'd1 << 1, 1, 1,  0, 0, 0, 0);
        step(24'd1 << 2, 1, 1,  0, 0, 0, 0);
        step(24'd0,      0, 31, 0, 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
